// File: rtl/register_file.sv
// Register file with combinational write-through reads and a per-register
// pending-write scoreboard; register 0 reads as zero and ignores writes/reserves.
module register_file #(
   parameter int w     = 8,
   parameter int sel_w = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [sel_w-1:0] x_sel,
   input  logic [sel_w-1:0] y_sel,
   input  logic [sel_w-1:0] z_sel,
   input  logic [w-1:0]     z,
   input  logic             z_we,
   input  logic             rsv,
   input  logic [sel_w-1:0] rsv_sel,
   output logic [w-1:0]     x,
   output logic [w-1:0]     y,
   output logic             x_busy,
   output logic             y_busy,
   output logic             any_busy
);

   localparam int N = 2**sel_w;

   logic [w-1:0] regs_q [N];
   logic [w-1:0] regs_d [N];
   logic [N-1:0] busy_q;
   logic [N-1:0] busy_d;

   logic wr_en;
   logic rsv_en;
   logic byp_x;
   logic byp_y;

   assign wr_en  = z_we && (z_sel != '0);
   assign rsv_en = rsv && (rsv_sel != '0);

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_en) begin
         regs_d[z_sel] = z;
         busy_d[z_sel] = 1'b0;
      end
      // Reserve is applied after the clear so a same-register collision stays busy.
      if (rsv_en) begin
         busy_d[rsv_sel] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign byp_x = wr_en && (z_sel == x_sel);
   assign byp_y = wr_en && (z_sel == y_sel);

   assign x        = byp_x ? z : regs_q[x_sel];
   assign y        = byp_y ? z : regs_q[y_sel];
   assign x_busy   = busy_q[x_sel] & ~byp_x;
   assign y_busy   = busy_q[y_sel] & ~byp_y;
   assign any_busy = |busy_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus random
// traffic compared every cycle against an array-based behavioural model.
module tb_register_file;

   localparam int W  = 8;
   localparam int SW = 4;
   localparam int NR = 2**SW;

   logic          clk;
   logic          reset_n;
   logic [SW-1:0] x_sel, y_sel, z_sel, rsv_sel;
   logic [W-1:0]  z;
   logic          z_we, rsv;
   logic [W-1:0]  x, y;
   logic          x_busy, y_busy, any_busy;

   register_file #(.w(W), .sel_w(SW)) dut (
      .clk(clk), .reset_n(reset_n),
      .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel), .z(z), .z_we(z_we),
      .rsv(rsv), .rsv_sel(rsv_sel),
      .x(x), .y(y), .x_busy(x_busy), .y_busy(y_busy), .any_busy(any_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   bit run  = 1'b0;

   // Behavioural model: plain arrays of stored values and pending flags.
   logic [W-1:0] mem [NR];
   bit           bsy [NR];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NR; i++) begin
            mem[i] = '0;
            bsy[i] = 1'b0;
         end
      end else begin
         if (z_we && z_sel != 0) begin
            mem[z_sel] = z;
            bsy[z_sel] = 1'b0;
         end
         if (rsv && rsv_sel != 0) bsy[rsv_sel] = 1'b1;
      end
   end

   function automatic logic [W-1:0] exp_rd(input logic [SW-1:0] s);
      if (s == 0) return '0;
      if (z_we && z_sel == s) return z;
      return mem[s];
   endfunction

   function automatic logic exp_busy(input logic [SW-1:0] s);
      if (s == 0) return 1'b0;
      if (z_we && z_sel == s) return 1'b0;
      return bsy[s];
   endfunction

   function automatic logic exp_any();
      logic a = 1'b0;
      for (int i = 1; i < NR; i++) a |= bsy[i];
      return a;
   endfunction

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (run && reset_n) begin
         chk("x",        x,        exp_rd(x_sel));
         chk("y",        y,        exp_rd(y_sel));
         chk("x_busy",   x_busy,   exp_busy(x_sel));
         chk("y_busy",   y_busy,   exp_busy(y_sel));
         chk("any_busy", any_busy, exp_any());
      end
   end

   task automatic idle();
      x_sel = '0; y_sel = '0; z_sel = '0; rsv_sel = '0;
      z = '0; z_we = 1'b0; rsv = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         mem[i] = '0;
         bsy[i] = 1'b0;
      end
      idle();
      reset_n = 1'b0;
      #12 reset_n = 1'b1;
      run = 1'b1;
      tick();

      chk("rst_x", x, 8'h00);
      chk("rst_any", any_busy, 1'b0);

      // Asynchronous reset mid-cycle after writing r3 and reserving r6.
      z_we = 1; z_sel = 3; z = 8'h5A; rsv = 1; rsv_sel = 6;
      tick();
      idle(); x_sel = 3;
      #1 chk("r3_before_rst", x, 8'h5A);
      chk("any_before_rst", any_busy, 1'b1);
      reset_n = 1'b0;
      #1 chk("rst_async_x", x, 8'h00);
      chk("rst_async_any", any_busy, 1'b0);
      #1 reset_n = 1'b1;
      tick();

      // Write r5 with bypass read in the same cycle.
      z_we = 1; z_sel = 5; z = 8'hA7; x_sel = 5;
      #1 chk("bypass_x", x, 8'hA7);
      tick();
      z_we = 0;
      #1 chk("stored_x", x, 8'hA7);
      tick();

      // Register 0 ignores writes and reserves.
      idle(); z_we = 1; z_sel = 0; z = 8'hFF; rsv = 1; rsv_sel = 0; x_sel = 0;
      #1 chk("r0_x_byp", x, 8'h00);
      chk("r0_busy_byp", x_busy, 1'b0);
      tick();
      idle();
      #1 chk("r0_x", x, 8'h00);
      chk("r0_xbusy", x_busy, 1'b0);
      chk("r0_any", any_busy, 1'b0);

      // Scoreboard: reserve r7, idle, then write it.
      rsv = 1; rsv_sel = 7;
      tick();
      idle(); y_sel = 7;
      for (int i = 0; i < 3; i++) begin
         #1 chk("r7_busy_idle", y_busy, 1'b1);
         tick();
      end
      z_we = 1; z_sel = 7; z = 8'h12;
      #1 chk("r7_busy_wr", y_busy, 1'b0);
      tick();
      idle(); y_sel = 7;
      #1 chk("r7_busy_after", y_busy, 1'b0);
      chk("r7_data", y, 8'h12);
      chk("r7_any", any_busy, 1'b0);

      // Same-edge reserve and write on r2: set wins.
      rsv = 1; rsv_sel = 2;
      tick();
      rsv = 1; rsv_sel = 2; z_we = 1; z_sel = 2; z = 8'h33;
      tick();
      idle(); x_sel = 2;
      #1 chk("r2_data", x, 8'h33);
      chk("r2_busy", x_busy, 1'b1);

      // Dual read, then independent reserve/write.
      z_we = 1; z_sel = 4; z = 8'h0C;
      tick();
      idle(); x_sel = 4; y_sel = 4;
      #1 chk("r4_x", x, 8'h0C);
      chk("r4_y", y, 8'h0C);
      rsv = 1; rsv_sel = 9; z_we = 1; z_sel = 4; z = 8'h0D;
      tick();
      idle(); x_sel = 4; y_sel = 9;
      #1 chk("r4_new", x, 8'h0D);
      chk("r4_busy", x_busy, 1'b0);
      chk("r9_busy", y_busy, 1'b1);
      tick();

      // Random traffic with occasional mid-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         x_sel   = SW'($urandom_range(0, NR-1));
         y_sel   = ($urandom_range(0, 3) == 0) ? x_sel : SW'($urandom_range(0, NR-1));
         z_sel   = ($urandom_range(0, 2) == 0) ? x_sel : SW'($urandom_range(0, NR-1));
         rsv_sel = ($urandom_range(0, 3) == 0) ? z_sel : SW'($urandom_range(0, NR-1));
         z       = W'($urandom);
         z_we    = ($urandom_range(0, 1) == 1);
         rsv     = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
         tick();
      end

      idle();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
